// File: rtl/add64_serial.sv
// Serial 64-bit adder: feeds one 16-bit carry-lookahead slice four times, chaining carries through a register.
// Optional ADD64_SUB_EN adds a 'sub' input that turns the block into a - b.

module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [15:0] g, p, c;
   logic [3:0]  grp_g, grp_p;
   logic [4:0]  grp_c;

   assign g = a & b;
   assign p = a ^ b;

   // Group generate/propagate per nibble; nibble carries come from the lookahead chain.
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      c     = '0;
      grp_c[0] = cin;
      for (int j = 0; j < 4; j++) begin
         grp_g[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         grp_p[j] = &p[4*j +: 4];
         grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0) c[i] = grp_c[i/4];
         else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
   end

   assign s    = p ^ c;
   assign cout = grp_c[4];
endmodule

module add64_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
`ifdef ADD64_SUB_EN
   input  logic        sub,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] s,
   output logic        cout,
   output logic        ovf
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [1:0]  k;
   logic        carry;
   logic [63:0] op_a, op_b;
   logic [15:0] slice_a, slice_b, slice_s;
   logic        slice_cout;
   logic        accept;
   logic [63:0] b_eff;
   logic        cin_eff;

`ifdef ADD64_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_ready && in_valid && !rst;

   assign slice_a = op_a[{k, 4'b0000} +: 16];
   assign slice_b = op_b[{k, 4'b0000} +: 16];

   cla_16bit u_cla (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // NOTE: operand registers are pure datapath, loaded only on accept; they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= a;
         op_b <= b_eff;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= 2'd0;
         carry <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= cin_eff;
                  k     <= 2'd0;
                  state <= RUN;
               end
            end
            RUN: begin
               s[{k, 4'b0000} +: 16] <= slice_s;
               carry <= slice_cout;
               k     <= k + 2'd1;
               if (k == 2'd3) begin
                  cout  <= slice_cout;
                  ovf   <= (op_a[63] == op_b[63]) && (slice_s[15] != op_a[63]);
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
